if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage with a prefetch buffer. It issues sequential fetches to a synchronous instruction memory and buffers each returned instruction with its next-sequential PC in a FIFO of configurable depth. Instructions are delivered to the ID stage over a valid/ready handshake. It sits at the head of the pipeline; a taken branch from a later stage flushes the buffer and redirects fetch.

## Interface
- ADDR_WIDTH, 32, PC/address width
- INST_WIDTH, 32, instruction width
- FIFO_DEPTH, 4, prefetch entries; legal values 2..16
- RESET_PC, 0, first fetch address after reset
- PC_STEP, 4, sequential address increment
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- branch_taken  in  1  redirect request from a later stage
- branch_address  in  ADDR_WIDTH  redirect target
- mem_req  out  1  fetch request this cycle
- mem_addr  out  ADDR_WIDTH  fetch address, valid when mem_req=1
- mem_rdata  in  INST_WIDTH  instruction for the request of the previous cycle; fixed 1-cycle latency; memory always accepts
- out_valid  out  1  out_inst/out_pc hold a valid entry
- out_ready  in  1  ID stage accepts (driven as ~freeze by the hazard unit)
- out_inst  out  INST_WIDTH  head-of-FIFO instruction
- out_pc  out  ADDR_WIDTH  head entry's fetch address + PC_STEP
- fifo_count  out  clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- State: fetch_pc, inflight flag (request issued last cycle), FIFO storage (circular, rd/wr pointers), count.
- pop = out_valid & out_ready.
- out_valid = (count != 0) & ~branch_taken.
- Issue: mem_req = ~rst & ~branch_taken & (count + inflight - pop < FIFO_DEPTH). On issue: mem_addr = fetch_pc, fetch_pc <= fetch_pc + PC_STEP, inflight <= 1; else inflight <= 0.
- Response: when inflight=1 and branch_taken=0, push {mem_rdata, issued_addr + PC_STEP} at wr pointer. The issue rule guarantees the push never overflows; an overflowing push is an assertion failure.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Branch (branch_taken=1): count <= 0; rd/wr pointers reset; any arriving response discarded; no issue this cycle; inflight <= 0; fetch_pc <= branch_address. Branch overrides a freeze (out_ready=0).
- Pointers wrap modulo FIFO_DEPTH. Address arithmetic wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC + 4 = 0x0).
- out_inst/out_pc are undefined when out_valid=0; the bench does not check them in that case.

## Timing
- Reset: fetch_pc=RESET_PC, count=0, inflight=0, pointers=0. Outputs during and after reset: out_valid=0, mem_req=0 while rst=1, fifo_count=0.
- First request in the first cycle with rst=0. out_valid rises 2 cycles after the issue cycle: issue at t, write at end of t+1, visible at t+2.
- Redirect latency: branch at cycle b gives request to branch_address at b+1 and out_valid at b+3.
- Steady state with out_ready=1: one instruction per cycle for any FIFO_DEPTH >= 2.
- Freeze (out_ready=0): fetch continues until count + inflight = FIFO_DEPTH, then mem_req=0. The head entry holds stable. Release resumes pop in the same cycle.
- Reset mid-operation: the buffer is cleared and any response arriving during reset is discarded. The first fetch after rst falls goes to RESET_PC.

## Test plan
- Reset then out_ready=1, memory word[a]=a: out_pc sequence 4, 8, 12… with out_inst 0, 4, 8…. First out_valid in cycle 2 after reset release, then one per cycle.
- Hold out_ready=0 with FIFO_DEPTH=4: fifo_count reaches 4, mem_req=0 afterward, head stays out_pc=4. Release: 4 pops in 4 consecutive cycles, no gap.
- branch_taken with branch_address=0x100 while FIFO holds 3 entries and a response is arriving: fifo_count=0 next cycle, mem_addr=0x100 at b+1, first out_pc=0x104 at b+3, no stale entry delivered.
- branch_taken while out_ready=0: redirect still takes effect, out_valid=0 in the branch cycle.
- fetch_pc near 0xFFFFFFF8: out_pc sequence 0xFFFFFFFC, 0x0, 0x4.
- rst asserted for one cycle during a full-buffer freeze: out_valid=0, fifo_count=0 next cycle, refetch from RESET_PC.

Source files
------------

// File: rtl/if_prefetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage_if
// Groups the fetch-stage bus signals: the redirect request from a later
// stage, the instruction-memory request/response pair and the valid/ready
// delivery channel towards the ID stage.
//   master : the fetch stage (drives mem_req/mem_addr and the out_* channel)
//   slave  : the environment (memory, branch unit, ID stage)
// ----------------------------------------------------------------------------
interface if_prefetch_stage_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_address;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [INST_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [INST_WIDTH-1:0] out_inst;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    input  branch_taken, branch_address, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_inst, out_pc
  );

  modport slave (
    output branch_taken, branch_address, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_inst, out_pc
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// if_prefetch_stage
// Instruction-fetch stage with a prefetch FIFO. Sequential fetches are issued
// to a synchronous memory with a fixed one-cycle read latency; every response
// is stored with its next-sequential PC and handed to ID over valid/ready.
// A taken branch empties the buffer, drops any arriving response and
// redirects fetch to branch_address.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   bus        : if_prefetch_stage_if.master (redirect, memory, ID channel)
//   fifo_count : current number of buffered entries
// ----------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4),
  localparam int unsigned          CNT_W      = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned          PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  if_prefetch_stage_if.master  bus,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [ADDR_WIDTH-1:0] issued_addr_r;
  logic                  inflight_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [INST_WIDTH-1:0] inst_mem_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_r   [FIFO_DEPTH];

  logic                  valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;
  logic [CNT_W:0]        pending_s;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake and issue decisions for the current cycle.
  always_comb begin
    valid_s   = (count_r != '0) & ~bus.branch_taken & ~rst;
    pop_s     = valid_s & bus.out_ready;
    push_s    = inflight_r & ~bus.branch_taken & ~rst;
    // Slots already claimed (stored + in flight) after this cycle's pop; a
    // new request is allowed only if its response is sure to find room.
    pending_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r}
              - {{CNT_W{1'b0}}, pop_s};
    issue_s   = ~rst & ~bus.branch_taken & (pending_s < DEPTH_C);
  end

  assign bus.mem_req   = issue_s;
  assign bus.mem_addr  = fetch_pc_r;
  assign bus.out_valid = valid_s;
  assign bus.out_inst  = inst_mem_r[rd_ptr_r];
  assign bus.out_pc    = pc_mem_r[rd_ptr_r];
  assign fifo_count    = count_r;

  // Fetch PC, in-flight tracking, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      issued_addr_r <= '0;
      inflight_r    <= 1'b0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      count_r       <= '0;
    end else if (bus.branch_taken) begin
      fetch_pc_r <= bus.branch_address;
      inflight_r <= 1'b0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
    end else begin
      if (issue_s) begin
        fetch_pc_r    <= fetch_pc_r + PC_STEP;
        issued_addr_r <= fetch_pc_r;
        inflight_r    <= 1'b1;
      end else begin
        inflight_r    <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wr_ptr_r] <= bus.mem_rdata;
      pc_mem_r[wr_ptr_r]   <= issued_addr_r + PC_STEP;
    end
  end

  if_prefetch_stage_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );

endmodule

// ----------------------------------------------------------------------------
// if_prefetch_stage_chk
// Property checker: a response must never be pushed into a full buffer
// without a simultaneous pop.
// ----------------------------------------------------------------------------
module if_prefetch_stage_chk #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

  // Overflow guard on the prefetch buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == FULL_C)));
endmodule

// File: tb/tb_if_prefetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_stage
// Self-checking bench for if_prefetch_stage (FIFO_DEPTH=4). A queue-based
// reference model predicts, every cycle, the occupancy, the request, the
// fetch address and the head entry. Directed phases follow the test plan,
// then a randomized phase mixes resets, redirects and freezes.
// ----------------------------------------------------------------------------
module tb_if_prefetch_stage;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic       clk;
  logic       rst;
  logic [2:0] fifo_count;

  if_prefetch_stage_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) ifc ();

  if_prefetch_stage #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (32'h0000_0004)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc),
    .fifo_count (fifo_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mem_xor  = 32'h0;

  // reference model state
  ent_t        buf_q[$];
  ent_t        fl_q[$];
  logic [31:0] fetch_m;

  // deliveries observed on the ID channel
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];
  int          dlv_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: word[a] = a ^ mem_xor, one-cycle latency
  always @(posedge clk) ifc.mem_rdata <= ifc.mem_addr ^ mem_xor;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_dlv();
    dlv_pc.delete();
    dlv_inst.delete();
    dlv_cyc.delete();
  endtask

  // One clock cycle: drive inputs, check against model, advance model.
  task automatic step(input logic r, input logic b, input logic [31:0] ba,
                      input logic rdy);
    logic exp_valid, exp_pop, exp_req;
    ent_t e;
    rst                = r;
    ifc.branch_taken   = b;
    ifc.branch_address = ba;
    ifc.out_ready      = rdy;
    @(negedge clk);
    exp_valid = !r && !b && (buf_q.size() != 0);
    exp_pop   = exp_valid && rdy;
    exp_req   = !r && !b &&
                ((buf_q.size() + fl_q.size() - (exp_pop ? 1 : 0)) < DEPTH);
    check_eq("fifo_count", 64'(fifo_count), 64'(buf_q.size()));
    check_eq("out_valid", 64'(ifc.out_valid), 64'(exp_valid));
    check_eq("mem_req", 64'(ifc.mem_req), 64'(exp_req));
    if (exp_req) check_eq("mem_addr", 64'(ifc.mem_addr), 64'(fetch_m));
    if (exp_valid) begin
      check_eq("out_pc", 64'(ifc.out_pc), 64'(buf_q[0].pc));
      check_eq("out_inst", 64'(ifc.out_inst), 64'(buf_q[0].inst));
    end
    if (ifc.out_valid === 1'b1 && rdy) begin
      dlv_pc.push_back(ifc.out_pc);
      dlv_inst.push_back(ifc.out_inst);
      dlv_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (r) begin
      buf_q.delete();
      fl_q.delete();
      fetch_m = 32'h0;
    end else if (b) begin
      buf_q.delete();
      fl_q.delete();
      fetch_m = ba;
    end else begin
      if (exp_pop) void'(buf_q.pop_front());
      if (fl_q.size() != 0) buf_q.push_back(fl_q.pop_front());
      if (exp_req) begin
        e.pc   = fetch_m + 32'd4;
        e.inst = fetch_m ^ mem_xor;
        fl_q.push_back(e);
        fetch_m = fetch_m + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  int c0;
  int bcyc;

  initial begin
    logic        r, b, rdy;
    logic [31:0] ba;
    rst                = 1'b1;
    ifc.branch_taken   = 1'b0;
    ifc.branch_address = 32'h0;
    ifc.out_ready      = 1'b0;
    fetch_m            = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step(1'b1, 1'b0, 32'h0, 1'b1);

    // sequential stream with out_ready=1
    clear_dlv();
    c0 = cyc;
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("first_valid_lat", 64'(dlv_cyc[0] - c0), 64'd2);
    check_eq("seq_pc0", 64'(dlv_pc[0]), 64'h4);
    check_eq("seq_pc1", 64'(dlv_pc[1]), 64'h8);
    check_eq("seq_pc2", 64'(dlv_pc[2]), 64'hC);
    check_eq("seq_inst1", 64'(dlv_inst[1]), 64'h4);
    check_eq("seq_inst2", 64'(dlv_inst[2]), 64'h8);
    check_eq("seq_rate", 64'(dlv_cyc[9] - dlv_cyc[0]), 64'd9);

    // freeze fills the buffer, head holds, release drains without gaps
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("freeze_count", 64'(fifo_count), 64'd4);
    check_eq("freeze_req", 64'(ifc.mem_req), 64'd0);
    check_eq("freeze_head", 64'(ifc.out_pc), 64'h4);
    clear_dlv();
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("drain_n", 64'(dlv_pc.size()), 64'd4);
    check_eq("drain_gap", 64'(dlv_cyc[3] - dlv_cyc[0]), 64'd3);
    check_eq("drain_last", 64'(dlv_pc[3]), 64'h10);

    // branch while 3 entries held and a response is arriving
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("pre_br_count", 64'(fifo_count), 64'd3);
    bcyc = cyc;
    step(1'b0, 1'b1, 32'h100, 1'b0);
    check_eq("br_count", 64'(fifo_count), 64'd0);
    clear_dlv();
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("br_first_pc", 64'(dlv_pc[0]), 64'h104);
    check_eq("br_latency", 64'(dlv_cyc[0] - bcyc), 64'd3);

    // branch overrides a freeze
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0);
    clear_dlv();
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("frz_br_pc", 64'(dlv_pc[0]), 64'h204);

    // address wrap
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    clear_dlv();
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_pc0", 64'(dlv_pc[0]), 64'hFFFF_FFFC);
    check_eq("wrap_pc1", 64'(dlv_pc[1]), 64'h0);
    check_eq("wrap_pc2", 64'(dlv_pc[2]), 64'h4);

    // one-cycle reset during a full-buffer freeze
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check_eq("rst_count", 64'(fifo_count), 64'd0);
    clear_dlv();
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("rst_refetch", 64'(dlv_pc[0]), 64'h4);

    // randomized mix
    mem_xor = $urandom;
    for (int i = 0; i < 800; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      b   = ($urandom_range(0, 9) == 0);
      ba  = ($urandom_range(0, 3) == 0)
            ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2))
            : ($urandom & 32'hFFFF_FFFC);
      rdy = ($urandom_range(0, 3) != 0);
      step(r, b, ba, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
